// File: rtl/cla_pipe_pkg.sv
// Shared constants for the pipelined carry-lookahead adder/subtractor.
package cla_pipe_pkg;

  localparam logic OP_ADD    = 1'b0;
  localparam logic OP_SUB    = 1'b1;
  localparam int   CLA_SLICE = 4;

endpackage

// File: rtl/cla4.sv
// 4-bit carry-lookahead adder block.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c_in);
    s     = p ^ c[3:0];
    c_out = c[4];
  end

endmodule

// File: rtl/cla_pipe_stage.sv
// One W-bit pipeline slice: chained cla4 blocks plus registered carry and valid.
module cla_pipe_stage
  import cla_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv,
  input  logic         valid_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] sum_o,
  output logic         valid_o,
  output logic         c_o,
  output logic         c_msb_o
);

  localparam int NB = W / CLA_SLICE;

  logic [NB:0] chain;
  logic        valid_d, valid_q;
  logic        c_d, c_q;
  logic        c_msb_d, c_msb_q;

  assign chain[0] = c_i;

  for (genvar j = 0; j < NB; j++) begin : g_cla
    cla4 u_cla4 (
      .a     (a_i[CLA_SLICE*j +: CLA_SLICE]),
      .b     (b_i[CLA_SLICE*j +: CLA_SLICE]),
      .c_in  (chain[j]),
      .s     (sum_o[CLA_SLICE*j +: CLA_SLICE]),
      .c_out (chain[j+1])
    );
  end

  // Carry into the MSB recovered from the MSB sum bit; only the last slice's copy feeds ovf.
  always_comb begin
    valid_d = valid_i;
    c_d     = chain[NB];
    c_msb_d = a_i[W-1] ^ b_i[W-1] ^ sum_o[W-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      c_q     <= 1'b0;
      c_msb_q <= 1'b0;
    end else if (adv) begin
      valid_q <= valid_d;
      c_q     <= c_d;
      c_msb_q <= c_msb_d;
    end
  end

  assign valid_o = valid_q;
  assign c_o     = c_q;
  assign c_msb_o = c_msb_q;

endmodule

// File: rtl/cla_pipe.sv
// Pipelined N-bit CLA adder/subtractor, one slice per stage, valid/ready on both sides.
module cla_pipe
  import cla_pipe_pkg::*;
#(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         ovf,
  output logic         zero
);

  if (STAGES < 1 || (N % (CLA_SLICE * STAGES)) != 0) begin : g_bad_cfg
    $error("cla_pipe: N must be a multiple of 4*STAGES");
  end

  localparam int W = N / STAGES;

  logic              adv;
  logic [N-1:0]      b_eff;
  logic [N-1:0]      a_fwd   [STAGES];
  logic [N-1:0]      b_fwd   [STAGES];
  logic [N-1:0]      dsk_fwd [STAGES];
  logic [STAGES-1:0] v_q, c_q, cm_q;
  logic [N-1:0]      sum_nxt;
  logic              zero_d, zero_q;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = (op == OP_SUB) ? ~b : b;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [N-1:0] a_in, b_in, lo_in;
    logic         v_in, c_k;
    logic [W-1:0] s_k;
    logic [N-1:0] dsk_d, dsk_q;

    if (k == 0) begin : g_head
      assign a_in  = a;
      assign b_in  = b_eff;
      assign lo_in = '0;
      assign v_in  = in_valid;
      assign c_k   = c_in;
    end else begin : g_body
      assign a_in  = a_fwd[k-1];
      assign b_in  = b_fwd[k-1];
      assign lo_in = dsk_fwd[k-1];
      assign v_in  = v_q[k-1];
      assign c_k   = c_q[k-1];
    end

    cla_pipe_stage #(.W(W)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .adv     (adv),
      .valid_i (v_in),
      .a_i     (a_in[W-1:0]),
      .b_i     (b_in[W-1:0]),
      .c_i     (c_k),
      .sum_o   (s_k),
      .valid_o (v_q[k]),
      .c_o     (c_q[k]),
      .c_msb_o (cm_q[k])
    );

    // De-skew: merge this slice into the lower slices that arrived alongside it.
    always_comb begin
      dsk_d = lo_in | (N'(s_k) << (W * k));
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        dsk_q <= '0;
      end else if (adv) begin
        dsk_q <= dsk_d;
      end
    end

    assign dsk_fwd[k] = dsk_q;

    if (k < STAGES - 1) begin : g_skew
      logic [N-1:0] a_sk_d, a_sk_q, b_sk_d, b_sk_q;

      always_comb begin
        a_sk_d = a_in >> W;
        b_sk_d = b_in >> W;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_sk_q <= '0;
          b_sk_q <= '0;
        end else if (adv) begin
          a_sk_q <= a_sk_d;
          b_sk_q <= b_sk_d;
        end
      end

      assign a_fwd[k] = a_sk_q;
      assign b_fwd[k] = b_sk_q;
    end else begin : g_tail
      assign a_fwd[k] = '0;
      assign b_fwd[k] = '0;
      assign sum_nxt  = dsk_d;
    end
  end

  always_comb begin
    zero_d = (sum_nxt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
    end else if (adv) begin
      zero_q <= zero_d;
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = dsk_fwd[STAGES-1];
  assign c_out     = c_q[STAGES-1];
  assign ovf       = c_q[STAGES-1] ^ cm_q[STAGES-1];
  assign zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe.sv
// Scoreboard bench for cla_pipe at N=16, STAGES=4 with directed vectors.
module tb_cla_pipe;

  localparam int N      = 16;
  localparam int STAGES = 4;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, c_in, op;
  logic         out_valid, out_ready, c_out, ovf, zero;
  logic [N-1:0] a, b, sum;

  typedef struct {
    int           id;
    logic [N-1:0] sum;
    logic         c_out;
    logic         ovf;
    logic         zero;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp   = 0;
  int          n_bad   = 0;
  int          beat_id = 0;
  logic [15:0] pat;

  always #5 clk = ~clk;

  cla_pipe #(.N(N), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf),
    .zero      (zero)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Monitor: every output handshake pops the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_result: got sum=%h c_out=%b, want no output", sum, c_out);
      end else begin
        e = exp_q.pop_front();
        if ({sum, c_out, ovf, zero} !== {e.sum, e.c_out, e.ovf, e.zero}) begin
          n_bad++;
          $display("FAIL beat%0d: got sum=%h c_out=%b ovf=%b zero=%b, want sum=%h c_out=%b ovf=%b zero=%b",
                   e.id, sum, c_out, ovf, zero, e.sum, e.c_out, e.ovf, e.zero);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is captured.
  task automatic send(input logic [N-1:0] va, input logic [N-1:0] vb, input logic vc,
                      input logic vop, input logic [N-1:0] es, input logic ec,
                      input logic eo, input logic ez, input bit track);
    int   waited = 0;
    exp_t e;
    a        = va;
    b        = vb;
    c_in     = vc;
    op       = vop;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 50) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, want 1");
        break;
      end
    end
    if (track && in_ready) begin
      e.id    = beat_id;
      e.sum   = es;
      e.c_out = ec;
      e.ovf   = eo;
      e.zero  = ez;
      exp_q.push_back(e);
    end
    beat_id++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    repeat (STAGES + 2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int stale;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    c_in      = 1'b0;
    op        = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("in_ready_during_reset", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sum", sum, 0);
    check("rst_flags", {c_out, ovf, zero}, 3'b000);
    @(posedge clk);
    #1;

    // Directed arithmetic vectors: a, b, c_in, op -> sum, c_out, ovf, zero
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    send(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    send(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
    send(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b1);
    send(16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
    send(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1);
    send(16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    // Back-to-back: 8 beats, valid expected on sample slots 4..11 with no gaps
    pat = '0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(N'(i), N'(i * 16'h1000), 1'b0, 1'b0, N'(i * 16'h1001), 1'b0, 1'b0, (i == 0), 1'b1);
      end
      begin
        for (int n = 0; n < 16; n++) begin
          @(negedge clk);
          pat[n] = out_valid;
        end
      end
    join
    check("b2b_valid_pattern", pat, 16'h0FF0);
    drain();

    // Backpressure: fill 4 beats with out_ready low, hold for 6 cycles
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(N'((i + 1) * 16'h0100), 16'h0001, 1'b0, 1'b0, N'((i + 1) * 16'h0100 + 1), 1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_sum_hold", sum, 16'h0101);
      check("bp_flags_hold", {c_out, ovf, zero}, 3'b000);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    pat = '0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      pat[n] = out_valid;
    end
    check("bp_release_pattern", pat[4:0], 5'b01111);
    drain();

    // Reset with 3 beats in flight: nothing may come out for them
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0);
    send(16'h4444, 16'h1111, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
    send(16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("rst_mid_no_stale", stale, 0);
    @(posedge clk);
    #1;
    pat = '0;
    fork
      send(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b1);
      begin
        for (int n = 0; n < 8; n++) begin
          @(negedge clk);
          pat[n] = out_valid;
        end
      end
    join
    check("post_rst_latency", pat[7:0], 8'h10);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cla_pipe.md
Name: cla_pipe

Overview:
- Pipelined, parametrised carry-lookahead adder/subtractor built from the existing 4-bit CLA block (cla4).
- Splits the N-bit operation into STAGES equal slices, one slice per pipeline stage, with a registered carry between stages.
- Uses a valid/ready handshake on input and output, so it can sit directly in streaming datapaths and CGRA processing elements.
- Adds a subtract mode and signed-overflow/zero flags on top of the plain combinational adder.

Parameters:
- N, 32, operand width; must be a multiple of 4*STAGES (compile-time check, elaboration error otherwise).
- STAGES, 4, pipeline depth and slice count; 1..N/4. Each stage handles W = N/STAGES bits.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  N  operand A.
- b  in  N  operand B.
- c_in  in  1  carry-in to bit 0.
- op  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  N  result.
- c_out  out  1  carry out of bit N-1.
- ovf  out  1  signed two's-complement overflow.
- zero  out  1  sum == 0.

Behaviour:
- Arithmetic:
  - op=0: {c_out,sum} = a + b + c_in.
  - op=1: {c_out,sum} = a + ~b + c_in. Plain a-b requires c_in=1.
  - c_out=0 on subtract means a borrow occurred.
  - ovf = carry into bit N-1 XOR carry out of bit N-1.
  - zero is computed from the final sum in the last stage, with no extra cycle.
- Slicing:
  - Stage k (0..STAGES-1) adds bits [W*k+W-1 : W*k] using W/4 chained cla4 instances.
  - Stage k's carry-in is the registered carry from stage k-1; stage 0 uses c_in.
  - Unprocessed operand slices (and the inverted-b bits) are carried forward in skew registers.
  - Finished sum slices are carried forward in de-skew registers, so all N sum bits emerge aligned.
- Latency and throughput:
  - A beat accepted at edge t produces out_valid=1 with its result after edge t+STAGES.
  - Throughput is one beat per cycle when out_ready=1.
  - Results leave in acceptance order.
- Handshake:
  - Global advance: adv = !out_valid || out_ready. in_ready = adv.
  - All stage registers and per-stage valid bits update only when adv=1. When adv=0, every register holds.
  - A beat transfers on in_valid && in_ready. If in_valid=0 while adv=1, a bubble (valid=0) enters stage 0.
  - Bubbles are not collapsed. Pipeline occupancy can include bubbles.
  - While out_valid && !out_ready, sum, c_out, ovf and zero are held stable.
  - in_ready is combinational from out_ready and out_valid. This is the only combinational in-to-out path.
- Reset:
  - All per-stage valid bits clear, so out_valid=0 after the reset edge.
  - sum, c_out, ovf and zero reset to 0.
  - Datapath skew registers also reset to 0, giving deterministic X-free simulation.
  - in_ready=1 during and after reset, since it follows from out_valid=0.
  - Reset mid-stream discards all in-flight beats. Nothing is emitted for them.
- Boundaries:
  - STAGES=1: a single registered adder with latency 1.
  - STAGES=N/4: one cla4 per stage.
  - a=b=0 with c_in=1: sum=1, zero=0.
  - Carry ripples across every slice boundary, e.g. an all-ones + 1 result.
  - Simultaneous output handshake and new input in the same cycle is the normal full-throughput case. No loss and no duplication.

Decomposition:
- Shared header cla_defs.vh holds:
  - OP_ADD=1'b0 and OP_SUB=1'b1.
  - A CLA_SLICE=4 constant used for parameter checks.
- Natural sub-module: cla_pipe_stage, one W-bit slice.
  - Contents: cla4 chain, carry register, valid bit, and enable input adv.
  - The last stage additionally exports the carry into its MSB for ovf.
- Top level instantiates STAGES copies in a generate loop, plus the skew and de-skew shift registers.

Test Plan:
- N=16, STAGES=4, add: a=0xFFFF, b=0x0001, c_in=0 -> after 4 cycles sum=0x0000, c_out=1, ovf=0, zero=1.
- Signed overflow, add: a=0x7FFF, b=0x0001, c_in=0 -> sum=0x8000, c_out=0, ovf=1, zero=0.
- Subtract: op=1, a=0x0005, b=0x0007, c_in=1 -> sum=0xFFFE, c_out=0 (borrow), ovf=0.
- Back-to-back: 8 consecutive beats with a=i, b=0x1000*i, op=0, out_ready=1 -> out_valid=1 on cycles 4..11, results in order, no gaps.
- Backpressure: fill with 4 beats, then hold out_ready=0 for 6 cycles.
  - Required: in_ready=0, outputs stable at beat 0's result throughout.
  - After releasing out_ready, all 4 results emerge in order on consecutive cycles.
- Reset mid-stream: assert rst for 1 cycle with 3 beats in flight -> out_valid=0 next cycle, no stale results later. A beat sent afterwards (0x1234+0x1111) returns 0x2345 after 4 cycles.
